// File: rtl/ahbl_arbiter_rr_if.sv
// Bus bundle for ahbl_arbiter_rr: N_PORTS upstream AHB-Lite master ports
// on the src_* side and one downstream slave connection on the dst_* side.
// The arbiter connects through modport "slave" because it is the slave of
// every upstream master. Modport "master" is the opposite view, used by
// whatever drives the masters and models the shared slave.
interface ahbl_arbiter_rr_if #(
   parameter int N_PORTS = 2,
   parameter int W_ADDR  = 32,
   parameter int W_DATA  = 32
);
   logic [N_PORTS-1:0]        src_hready;
   logic [N_PORTS-1:0]        src_hready_resp;
   logic [N_PORTS-1:0]        src_hresp;
   logic [N_PORTS*W_ADDR-1:0] src_haddr;
   logic [N_PORTS-1:0]        src_hwrite;
   logic [N_PORTS*2-1:0]      src_htrans;
   logic [N_PORTS*3-1:0]      src_hsize;
   logic [N_PORTS*3-1:0]      src_hburst;
   logic [N_PORTS*4-1:0]      src_hprot;
   logic [N_PORTS-1:0]        src_hmastlock;
   logic [N_PORTS*W_DATA-1:0] src_hwdata;
   logic [N_PORTS*W_DATA-1:0] src_hrdata;

   logic              dst_hready;
   logic              dst_hready_resp;
   logic              dst_hresp;
   logic [W_ADDR-1:0] dst_haddr;
   logic              dst_hwrite;
   logic [1:0]        dst_htrans;
   logic [2:0]        dst_hsize;
   logic [2:0]        dst_hburst;
   logic [3:0]        dst_hprot;
   logic              dst_hmastlock;
   logic [W_DATA-1:0] dst_hwdata;
   logic [W_DATA-1:0] dst_hrdata;
   logic [7:0]        dst_hmaster;

   modport slave (
      input  src_hready, src_haddr, src_hwrite, src_htrans, src_hsize,
             src_hburst, src_hprot, src_hmastlock, src_hwdata,
      output src_hready_resp, src_hresp, src_hrdata,
      output dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize,
             dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata, dst_hmaster,
      input  dst_hready_resp, dst_hresp, dst_hrdata
   );

   modport master (
      output src_hready, src_haddr, src_hwrite, src_htrans, src_hsize,
             src_hburst, src_hprot, src_hmastlock, src_hwdata,
      input  src_hready_resp, src_hresp, src_hrdata,
      input  dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize,
             dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata, dst_hmaster,
      output dst_hready_resp, dst_hresp, dst_hrdata
   );
endinterface

// File: rtl/ahbl_arbiter_rr.sv
// N:1 AHB-Lite arbiter with a fixed-priority or round-robin grant, grant
// holding over bursts and locked sequences, and a one-deep address-phase
// buffer per master port, so a master that loses arbitration stalls in
// its data phase.
module ahbl_arbiter_rr #(
   parameter int                   N_PORTS        = 2,
   parameter int                   W_ADDR         = 32,
   parameter int                   W_DATA         = 32,
   parameter int                   ARB_MODE       = 0,
   parameter logic [N_PORTS-1:0]   CONN_MASK      = '1,
   parameter logic [7:0]           MASTER_ID_BASE = 8'd0
) (
   input logic              clk,
   input logic              rst,
   ahbl_arbiter_rr_if.slave bus
);
   localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   typedef enum logic [1:0] {HT_IDLE, HT_BUSY, HT_NONSEQ, HT_SEQ} htrans_e;
   typedef enum logic [2:0] {HB_SINGLE, HB_INCR, HB_WRAP4, HB_INCR4,
                             HB_WRAP8, HB_INCR8, HB_WRAP16, HB_INCR16} hburst_e;

   typedef struct packed {
      logic [W_ADDR-1:0] haddr;
      logic              hwrite;
      logic [1:0]        htrans;
      logic [2:0]        hsize;
      logic [2:0]        hburst;
      logic [3:0]        hprot;
      logic              hmastlock;
   } aph_t;

   aph_t               live [N_PORTS];
   aph_t               act  [N_PORTS];
   aph_t               buf_q [N_PORTS];
   aph_t               buf_d [N_PORTS];
   aph_t               own, gsel;
   logic [N_PORTS-1:0] req, req_live, gnt_a, buf_wen;
   logic [N_PORTS-1:0] buf_valid_q, buf_valid_d;
   logic [N_PORTS-1:0] owner_q, owner_d, gnt_d_q, gnt_d_d;
   logic               hold_q, hold_d, hold_eff, found, accept, dst_hready;
   logic [3:0]         beats_q, beats_d, beats_new;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d, gnt_idx;
   logic [W_DATA-1:0]  wdata;

   // Per-port address phase: buffered copy when present, live bus otherwise
   always_comb begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
         live[i].haddr     = bus.src_haddr[i*W_ADDR +: W_ADDR];
         live[i].hwrite    = bus.src_hwrite[i];
         live[i].htrans    = bus.src_htrans[i*2 +: 2];
         live[i].hsize     = bus.src_hsize[i*3 +: 3];
         live[i].hburst    = bus.src_hburst[i*3 +: 3];
         live[i].hprot     = bus.src_hprot[i*4 +: 4];
         live[i].hmastlock = bus.src_hmastlock[i];
         act[i]      = buf_valid_q[i] ? buf_q[i] : live[i];
         req[i]      = act[i].htrans[1] & CONN_MASK[i];
         req_live[i] = live[i].htrans[1];
      end
   end

   // Owner view; a hold survives while the owner keeps its lock or is mid-burst (SEQ/BUSY)
   always_comb begin
      own = '0;
      for (int unsigned i = 0; i < N_PORTS; i++)
         if (owner_q[i]) own = act[i];
      hold_eff = hold_q & (own.hmastlock | own.htrans[0]);
   end

   // Grant selection: held owner, else lowest index, else round-robin after rr_ptr
   always_comb begin
      gnt_a = '0;
      found = 1'b0;
      if (rst) begin
         gnt_a = '0;
      end else if (hold_eff) begin
         gnt_a = owner_q;
      end else if (ARB_MODE == 0) begin
         for (int unsigned i = 0; i < N_PORTS; i++)
            if (!found && req[i]) begin
               gnt_a[i] = 1'b1;
               found    = 1'b1;
            end
      end else begin
         for (int unsigned i = 0; i < N_PORTS; i++)
            if (!found && req[i] && (i > 32'(rr_ptr_q))) begin
               gnt_a[i] = 1'b1;
               found    = 1'b1;
            end
         for (int unsigned i = 0; i < N_PORTS; i++)
            if (!found && req[i] && (i <= 32'(rr_ptr_q))) begin
               gnt_a[i] = 1'b1;
               found    = 1'b1;
            end
      end
   end

   // Downstream muxes: address phase by gnt_a, write data by data-phase owner
   always_comb begin
      gsel    = '0;
      gnt_idx = '0;
      wdata   = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
         if (gnt_a[i]) begin
            gsel    = act[i];
            gnt_idx = IW'(i);
         end
         if (gnt_d_q[i]) wdata = bus.src_hwdata[i*W_DATA +: W_DATA];
      end
      dst_hready = (gnt_d_q != '0) ? |(bus.src_hready & gnt_d_q) : 1'b1;
      accept     = dst_hready & |(gnt_a & req);
   end

   // Owner, hold, beat counter, round-robin pointer and data-phase grant
   always_comb begin
      owner_d   = owner_q;
      hold_d    = hold_q;
      beats_d   = beats_q;
      rr_ptr_d  = rr_ptr_q;
      beats_new = '0;
      gnt_d_d   = dst_hready ? gnt_a : gnt_d_q;
      if (accept) begin
         owner_d = gnt_a;
         if (gsel.htrans == HT_NONSEQ) begin
            rr_ptr_d = gnt_idx;
            case (gsel.hburst)
               HB_WRAP4,  HB_INCR4:  beats_new = 4'd3;
               HB_WRAP8,  HB_INCR8:  beats_new = 4'd7;
               HB_WRAP16, HB_INCR16: beats_new = 4'd15;
               default:              beats_new = 4'd0;
            endcase
         end else if (gsel.hburst != HB_INCR && beats_q != 4'd0) begin
            beats_new = beats_q - 4'd1;
         end
         beats_d = beats_new;
         hold_d  = gsel.hmastlock | (gsel.hburst == HB_INCR) | (beats_new != 4'd0);
      end else if (!hold_eff) begin
         hold_d = 1'b0;
      end
   end

   // Address-phase buffers: capture a live request that is not issued this cycle
   always_comb begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
         buf_wen[i]     = req_live[i] & bus.src_hready[i] & ~(gnt_a[i] & dst_hready);
         buf_valid_d[i] = buf_valid_q[i];
         buf_d[i]       = buf_q[i];
         if (gnt_a[i] & dst_hready) begin
            buf_valid_d[i] = 1'b0;
         end else if (buf_wen[i] & ~buf_valid_q[i]) begin
            buf_valid_d[i] = 1'b1;
            buf_d[i]       = live[i];
         end
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q     <= '0;
         hold_q      <= 1'b0;
         beats_q     <= '0;
         rr_ptr_q    <= IW'(N_PORTS - 1);
         gnt_d_q     <= '0;
         buf_valid_q <= '0;
         for (int unsigned i = 0; i < N_PORTS; i++) buf_q[i] <= '0;
      end else begin
         owner_q     <= owner_d;
         hold_q      <= hold_d;
         beats_q     <= beats_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_d_q     <= gnt_d_d;
         buf_valid_q <= buf_valid_d;
         for (int unsigned i = 0; i < N_PORTS; i++) buf_q[i] <= buf_d[i];
      end
   end

`ifdef SIM
   // A master must not issue a new address while its buffered one is pending
   always_ff @(posedge clk)
      if (!rst) assert ((buf_wen & buf_valid_q) == '0) else $error("address buffer overwrite");
`endif

   assign bus.dst_hready      = dst_hready;
   assign bus.dst_haddr       = gsel.haddr;
   assign bus.dst_hwrite      = gsel.hwrite;
   assign bus.dst_htrans      = gsel.htrans;
   assign bus.dst_hsize       = gsel.hsize;
   assign bus.dst_hburst      = gsel.hburst;
   assign bus.dst_hprot       = gsel.hprot;
   assign bus.dst_hmastlock   = gsel.hmastlock;
   assign bus.dst_hwdata      = wdata;
   assign bus.dst_hmaster     = (gnt_a != '0) ? MASTER_ID_BASE + 8'(gnt_idx) : 8'd0;
   assign bus.src_hready_resp = ~(buf_valid_q | gnt_d_q) | (gnt_d_q & {N_PORTS{bus.dst_hready_resp}});
   assign bus.src_hresp       = gnt_d_q & {N_PORTS{bus.dst_hresp}};
   assign bus.src_hrdata      = {N_PORTS{bus.dst_hrdata}};
endmodule

// File: tb/tb_ahbl_arbiter_rr.sv
// Scoreboard bench for ahbl_arbiter_rr: one fixed-priority 2-port instance
// and one round-robin 3-port instance. Each master port replays a short
// program and holds its address phase while its HREADY is low. Every
// transfer expected on dst is queued when the program is loaded, and a
// monitor pops and compares on each accepted dst address phase.
module tb_ahbl_arbiter_rr;
   typedef struct packed {
      logic [1:0]  tr;
      logic [31:0] a;
      logic [2:0]  b;
      logic        l;
      logic        w;
   } xf_t;

   typedef struct packed {
      logic [31:0] a;
      logic [7:0]  m;
      logic [1:0]  t;
   } ex_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   xf_t fp [2][16];
   xf_t rp [3][16];
   int  fl [2];
   int  fi [2];
   int  rl [3];
   int  ri [3];
   ex_t fq [$];
   ex_t rq [$];
   ex_t mf, mr;

   always #5 clk = ~clk;

   ahbl_arbiter_rr_if #(.N_PORTS(2), .W_ADDR(32), .W_DATA(32)) fif ();
   ahbl_arbiter_rr_if #(.N_PORTS(3), .W_ADDR(32), .W_DATA(32)) rif ();

   // Each master sees the arbiter's HREADYOUT as its HREADY
   assign fif.src_hready = fif.src_hready_resp;
   assign rif.src_hready = rif.src_hready_resp;

   ahbl_arbiter_rr #(.N_PORTS(2), .W_ADDR(32), .W_DATA(32), .ARB_MODE(0),
                     .CONN_MASK(2'b11), .MASTER_ID_BASE(8'h20)) u_fix (
      .clk(clk), .rst(rst), .bus(fif.slave));

   ahbl_arbiter_rr #(.N_PORTS(3), .W_ADDR(32), .W_DATA(32), .ARB_MODE(1),
                     .CONN_MASK(3'b111), .MASTER_ID_BASE(8'h00)) u_rr (
      .clk(clk), .rst(rst), .bus(rif.slave));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic clr();
      for (int i = 0; i < 2; i++) begin fl[i] = 0; fi[i] = 0; end
      for (int i = 0; i < 3; i++) begin rl[i] = 0; ri[i] = 0; end
   endtask

   task automatic addf(input int p, input logic [1:0] tr, input logic [31:0] a,
                       input logic [2:0] b, input logic l, input logic w);
      fp[p][fl[p]] = '{tr: tr, a: a, b: b, l: l, w: w};
      fl[p]++;
   endtask

   task automatic addr_(input int p, input logic [31:0] a);
      rp[p][rl[p]] = '{tr: 2'd2, a: a, b: 3'd0, l: 1'b0, w: 1'b0};
      rl[p]++;
   endtask

   task automatic drv();
      xf_t x;
      for (int i = 0; i < 2; i++) begin
         x = (fi[i] < fl[i]) ? fp[i][fi[i]] : '0;
         fif.src_htrans[i*2 +: 2]    = x.tr;
         fif.src_haddr[i*32 +: 32]   = x.a;
         fif.src_hburst[i*3 +: 3]    = x.b;
         fif.src_hmastlock[i]        = x.l;
         fif.src_hwrite[i]           = x.w;
         fif.src_hsize[i*3 +: 3]     = 3'd2;
         fif.src_hprot[i*4 +: 4]     = 4'd3;
         fif.src_hwdata[i*32 +: 32]  = 32'hCAFE0000 + 32'(i);
      end
      for (int i = 0; i < 3; i++) begin
         x = (ri[i] < rl[i]) ? rp[i][ri[i]] : '0;
         rif.src_htrans[i*2 +: 2]    = x.tr;
         rif.src_haddr[i*32 +: 32]   = x.a;
         rif.src_hburst[i*3 +: 3]    = x.b;
         rif.src_hmastlock[i]        = x.l;
         rif.src_hwrite[i]           = x.w;
         rif.src_hsize[i*3 +: 3]     = 3'd2;
         rif.src_hprot[i*4 +: 4]     = 4'd3;
         rif.src_hwdata[i*32 +: 32]  = 32'hBEEF0000 + 32'(i);
      end
   endtask

   // One bus cycle: sample each master's HREADY mid-cycle, then advance after the edge
   task automatic cyc();
      logic [1:0] fa;
      logic [2:0] ra;
      @(negedge clk);
      fa = fif.src_hready;
      ra = rif.src_hready;
      @(posedge clk);
      #1;
      if (!rst) begin
         for (int i = 0; i < 2; i++) if (fa[i] && fi[i] < fl[i]) fi[i]++;
         for (int i = 0; i < 3; i++) if (ra[i] && ri[i] < rl[i]) ri[i]++;
      end
      drv();
   endtask

   // Monitor: every accepted dst address phase must match the queue head
   always @(negedge clk) begin
      if (!rst && fif.dst_hready && fif.dst_htrans[1]) begin
         checks++;
         if (fq.size() == 0) begin
            errors++;
            $display("FAIL fix_issue actual a=%h m=%h expected nothing", fif.dst_haddr, fif.dst_hmaster);
         end else begin
            mf = fq.pop_front();
            if (fif.dst_haddr !== mf.a || fif.dst_hmaster !== mf.m || fif.dst_htrans !== mf.t) begin
               errors++;
               $display("FAIL fix_issue actual a=%h m=%h t=%h expected a=%h m=%h t=%h",
                        fif.dst_haddr, fif.dst_hmaster, fif.dst_htrans, mf.a, mf.m, mf.t);
            end
         end
      end
      if (!rst && rif.dst_hready && rif.dst_htrans[1]) begin
         checks++;
         if (rq.size() == 0) begin
            errors++;
            $display("FAIL rr_issue actual a=%h m=%h expected nothing", rif.dst_haddr, rif.dst_hmaster);
         end else begin
            mr = rq.pop_front();
            if (rif.dst_haddr !== mr.a || rif.dst_hmaster !== mr.m || rif.dst_htrans !== mr.t) begin
               errors++;
               $display("FAIL rr_issue actual a=%h m=%h t=%h expected a=%h m=%h t=%h",
                        rif.dst_haddr, rif.dst_hmaster, rif.dst_htrans, mr.a, mr.m, mr.t);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      fif.dst_hready_resp = 1'b1; fif.dst_hresp = 1'b0; fif.dst_hrdata = 32'h0;
      rif.dst_hready_resp = 1'b1; rif.dst_hresp = 1'b0; rif.dst_hrdata = 32'h0;
      clr();
      drv();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_fix_htrans", 32'(fif.dst_htrans), 32'd0);
      chk("rst_fix_hready", 32'(fif.dst_hready), 32'd1);
      chk("rst_fix_resp",   32'(fif.src_hready_resp), 32'h3);
      chk("rst_fix_hresp",  32'(fif.src_hresp), 32'h0);
      chk("rst_rr_resp",    32'(rif.src_hready_resp), 32'h7);
      rst = 1'b0;
      cyc(); cyc();

      // Uncontended read, zero added latency, data-phase wait passed through
      clr();
      addf(0, 2'd2, 32'h100, 3'd0, 1'b0, 1'b0);
      fq.push_back('{a: 32'h100, m: 8'h20, t: 2'd2});
      drv();
      #1;
      chk("s1_haddr",   fif.dst_haddr, 32'h100);
      chk("s1_hmaster", 32'(fif.dst_hmaster), 32'h20);
      cyc();
      fif.dst_hready_resp = 1'b0;
      #1;
      chk("s1_resp0_wait", 32'(fif.src_hready_resp[0]), 32'd0);
      cyc();
      fif.dst_hready_resp = 1'b1;
      #1;
      chk("s1_resp0_done", 32'(fif.src_hready_resp[0]), 32'd1);
      cyc(); cyc();

      // Simultaneous NONSEQ, fixed priority: port 1 issued from its buffer
      clr();
      addf(0, 2'd2, 32'h10, 3'd0, 1'b0, 1'b0);
      addf(1, 2'd2, 32'h20, 3'd0, 1'b0, 1'b0);
      fq.push_back('{a: 32'h10, m: 8'h20, t: 2'd2});
      fq.push_back('{a: 32'h20, m: 8'h21, t: 2'd2});
      drv();
      #1;
      chk("s2_resp1_addr", 32'(fif.src_hready_resp[1]), 32'd1);
      cyc();
      #1;
      chk("s2_resp1_stall", 32'(fif.src_hready_resp[1]), 32'd0);
      cyc();
      #1;
      chk("s2_resp1_data", 32'(fif.src_hready_resp[1]), 32'd1);
      cyc(); cyc();

      // Round-robin over three continuously requesting ports
      clr();
      addr_(0, 32'h1000); addr_(0, 32'h1004);
      addr_(1, 32'h2000); addr_(1, 32'h2004);
      addr_(2, 32'h3000); addr_(2, 32'h3004);
      rq.push_back('{a: 32'h1000, m: 8'h00, t: 2'd2});
      rq.push_back('{a: 32'h2000, m: 8'h01, t: 2'd2});
      rq.push_back('{a: 32'h3000, m: 8'h02, t: 2'd2});
      rq.push_back('{a: 32'h1004, m: 8'h00, t: 2'd2});
      rq.push_back('{a: 32'h2004, m: 8'h01, t: 2'd2});
      rq.push_back('{a: 32'h3004, m: 8'h02, t: 2'd2});
      drv();
      repeat (9) cyc();

      // INCR4 on port 1 holds the grant against higher-priority port 0
      clr();
      addf(1, 2'd2, 32'h200, 3'd3, 1'b0, 1'b0);
      addf(1, 2'd3, 32'h204, 3'd3, 1'b0, 1'b0);
      addf(1, 2'd3, 32'h208, 3'd3, 1'b0, 1'b0);
      addf(1, 2'd3, 32'h20C, 3'd3, 1'b0, 1'b0);
      addf(0, 2'd0, 32'h0,   3'd0, 1'b0, 1'b0);
      addf(0, 2'd2, 32'h300, 3'd0, 1'b0, 1'b0);
      fq.push_back('{a: 32'h200, m: 8'h21, t: 2'd2});
      fq.push_back('{a: 32'h204, m: 8'h21, t: 2'd3});
      fq.push_back('{a: 32'h208, m: 8'h21, t: 2'd3});
      fq.push_back('{a: 32'h20C, m: 8'h21, t: 2'd3});
      fq.push_back('{a: 32'h300, m: 8'h20, t: 2'd2});
      drv();
      repeat (7) cyc();

      // Locked sequence on port 0 with an IDLE inside the lock
      clr();
      addf(0, 2'd2, 32'h400, 3'd0, 1'b1, 1'b0);
      addf(0, 2'd0, 32'h0,   3'd0, 1'b1, 1'b0);
      addf(0, 2'd2, 32'h404, 3'd0, 1'b1, 1'b0);
      addf(1, 2'd0, 32'h0,   3'd0, 1'b0, 1'b0);
      addf(1, 2'd2, 32'h500, 3'd0, 1'b0, 1'b0);
      fq.push_back('{a: 32'h400, m: 8'h20, t: 2'd2});
      fq.push_back('{a: 32'h404, m: 8'h20, t: 2'd2});
      fq.push_back('{a: 32'h500, m: 8'h21, t: 2'd2});
      drv();
      cyc();
      #1;
      chk("s5_lock_idle", 32'(fif.dst_htrans), 32'd0);
      cyc();
      #1;
      chk("s5_p1_waits", 32'(fif.src_hready_resp[1]), 32'd0);
      repeat (4) cyc();

      // Two-cycle ERROR response on port 1's write data phase
      clr();
      addf(1, 2'd2, 32'h600, 3'd0, 1'b0, 1'b1);
      fq.push_back('{a: 32'h600, m: 8'h21, t: 2'd2});
      drv();
      cyc();
      fif.dst_hresp = 1'b1; fif.dst_hready_resp = 1'b0;
      #1;
      chk("s6_hresp_1st", 32'(fif.src_hresp), 32'h2);
      chk("s6_resp_1st",  32'(fif.src_hready_resp), 32'h1);
      chk("s6_hwdata",    fif.dst_hwdata, 32'hCAFE0001);
      cyc();
      fif.dst_hready_resp = 1'b1;
      #1;
      chk("s6_hresp_2nd", 32'(fif.src_hresp), 32'h2);
      chk("s6_resp_2nd",  32'(fif.src_hready_resp), 32'h3);
      cyc();
      fif.dst_hresp = 1'b0;
      #1;
      chk("s6_hresp_end", 32'(fif.src_hresp), 32'h0);
      cyc();

      // Reset asserted while the slave stalls and port 1 waits in its buffer
      clr();
      addf(0, 2'd2, 32'h700, 3'd0, 1'b0, 1'b0);
      addf(1, 2'd2, 32'h704, 3'd0, 1'b0, 1'b0);
      fq.push_back('{a: 32'h700, m: 8'h20, t: 2'd2});
      drv();
      cyc();
      fif.dst_hready_resp = 1'b0;
      #1;
      chk("s7_stall_resp", 32'(fif.src_hready_resp), 32'h0);
      rst = 1'b1;
      clr();
      addf(0, 2'd2, 32'h7F0, 3'd0, 1'b0, 1'b0);
      drv();
      #1;
      chk("s7_rst_htrans",  32'(fif.dst_htrans), 32'd0);
      chk("s7_rst_haddr",   fif.dst_haddr, 32'h0);
      chk("s7_rst_hmaster", 32'(fif.dst_hmaster), 32'h0);
      chk("s7_rst_hready",  32'(fif.dst_hready), 32'd1);
      chk("s7_rst_resp",    32'(fif.src_hready_resp), 32'h3);
      chk("s7_rst_hresp",   32'(fif.src_hresp), 32'h0);
      clr();
      drv();
      fif.dst_hready_resp = 1'b1;
      cyc();
      rst = 1'b0;
      repeat (3) cyc();

      chk("fix_queue_left", 32'(fq.size()), 32'd0);
      chk("rr_queue_left",  32'(rq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ahbl_arbiter_rr.md
Name: ahbl_arbiter_rr

Overview:
Parametrised N:1 AHB-Lite arbiter that replaces the strict-priority arbiter in the busfabric. It adds a selectable round-robin mode, grant holding across SEQ bursts and HMASTLOCK sequences, a per-port connection mask, and an HMASTER tag derived from the port index. It sits between the per-master splitters and a single shared slave, such as SRAM or the APB bridge. Each master port has a one-deep address-phase buffer, so a master that loses arbitration stalls in its data phase instead of dropping the transfer.

Parameters:
N_PORTS, 2, number of master ports (1..16)
W_ADDR, 32, address width
W_DATA, 32, data width
ARB_MODE, 0, 0 = fixed priority (port 0 highest), 1 = round-robin
CONN_MASK, {N_PORTS{1'b1}}, bit i clear: port i never requests; its transfers are buffered but never granted
MASTER_ID_BASE, 0, dst_hmaster = MASTER_ID_BASE + granted port index (8 bits)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
src_hready  in  N_PORTS  per-master HREADY
src_hready_resp  out  N_PORTS  per-master HREADYOUT
src_hresp  out  N_PORTS  per-master HRESP
src_haddr  in  N_PORTS*W_ADDR  concatenated, port 0 in the LSBs
src_hwrite  in  N_PORTS  HWRITE
src_htrans  in  N_PORTS*2  HTRANS
src_hsize  in  N_PORTS*3  HSIZE
src_hburst  in  N_PORTS*3  HBURST
src_hprot  in  N_PORTS*4  HPROT
src_hmastlock  in  N_PORTS  HMASTLOCK
src_hwdata  in  N_PORTS*W_DATA  write data
src_hrdata  out  N_PORTS*W_DATA  dst_hrdata broadcast to every port
dst_hready  out  1  HREADY to the slave
dst_hready_resp  in  1  slave HREADYOUT
dst_hresp  in  1  slave HRESP
dst_haddr / dst_hwrite / dst_htrans / dst_hsize / dst_hburst / dst_hprot / dst_hmastlock  out  W_ADDR/1/2/3/3/4/1  address phase of the granted port
dst_hwdata  out  W_DATA  write data of the data-phase owner
dst_hrdata  in  W_DATA  slave read data
dst_hmaster  out  8  tag of the granted port

Behaviour:
- actual[i]: buffer contents of port i if buf_valid[i], else the live src signals. req[i] = actual_htrans[i][1] & CONN_MASK[i].
- gnt_a (one-hot or zero, combinational):
  - If hold is set, gnt_a = owner.
  - Otherwise fixed mode grants the lowest-index request.
  - Otherwise round-robin mode grants the first request found searching from rr_ptr+1 upward with wrap-around.
- owner: register holding the last accepted grant; reset value 0.
- hold: register. On each accepted address phase (dst_hready & |(gnt_a & req)) it is set to the granted port's hmastlock, or to 1 if that port's hburst != SINGLE and the beat is not the last. It is cleared when the owner presents IDLE with hmastlock=0.
- Beat tracking: a per-owner beat counter handles INCR4/8/16 and WRAP4/8/16. INCR (undefined length) holds the grant while the owner's next htrans == SEQ.
- rr_ptr: updates to the granted index on each accepted NONSEQ; reset value N_PORTS-1.
- gnt_d: register, <= gnt_a when dst_hready; reset 0.
- dst_hready = |(src_hready & gnt_d) if gnt_d != 0, else 1.
- dst_htrans = 0 (IDLE) when gnt_a == 0.
- dst_hwdata is muxed by gnt_d from the live src_hwdata.
- Buffer write: buf_wen[i] = req_live[i] & src_hready[i] & ~(gnt_a[i] & dst_hready). buf_valid[i] clears when gnt_a[i] & dst_hready.
- Buffer write with buf_valid[i] already set is a protocol violation: it asserts under `ifdef SIM and has no other effect.
- src_hready_resp[i] = ~(buf_valid[i] | gnt_d[i]) | (gnt_d[i] & dst_hready_resp).
- src_hresp[i] = gnt_d[i] & dst_hresp. The two-cycle ERROR response passes through unchanged.
- Latency: zero added cycles for an uncontended transfer. A buffered transfer issues in the first cycle its grant coincides with dst_hready.
- Simultaneous requests: one grant per dst_hready cycle; losers are buffered.
- Reset mid-transfer: all registers clear immediately; outputs go to the reset values below.
- Reset values of outputs: dst_htrans=0, dst_hready=1, src_hready_resp all 1, src_hresp 0. The dst address-phase outputs and dst_hmaster follow the live src mux with gnt_a=0, i.e. 0.

Test Plan:
- Port 0 issues an uncontended read to 0x100 while port 1 is IDLE -> dst_haddr=0x100 in the same cycle, dst_hmaster=MASTER_ID_BASE, src_hready_resp[0] follows dst_hready_resp.
- Fixed mode, ports 0 and 1 NONSEQ in the same cycle (0x10, 0x20) -> 0x10 issued first, 0x20 from the buffer next cycle, src_hready_resp[1] low for exactly 1 extra cycle.
- Round-robin, 3 ports requesting continuously -> grant order 0,1,2,0,1,2, no port granted twice before the others.
- Port 1 INCR4 burst while port 0 requests -> all 4 beats of port 1 are contiguous on dst, and port 0 is granted only after the 4th beat.
- Port 0 sets hmastlock over two transfers while port 1 requests -> port 1 waits until port 0 goes IDLE with hmastlock=0.
- Slave returns an ERROR on port 1's data phase -> src_hresp=2'b10 for 2 cycles with src_hready_resp[1] = 0 then 1; port 0 is unaffected. Assert rst mid-stall -> all outputs at reset values the same cycle.
